// File: rtl/bram_1r1w_be_clr_if.sv
// Bus bundle for bram_1r1w_be_clr: byte-enabled write port, read port with
// completion pulse, and clear-engine control/status.
interface bram_1r1w_be_clr_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 256,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    // Handshake: a read on enb is taken in every IDLE cycle that has no clr_req.
    // There is no backpressure. doutb_valid pulses once per taken read, and
    // doutb is meaningful only in that cycle.
    logic                  clr_req;
    logic                  init_busy;
    logic                  ena;
    logic [NB-1:0]         wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dina;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  doutb_valid;
    logic                  dbg_state;

    modport master (
        output clr_req, ena, wea, addra, dina, enb, addrb,
        input  init_busy, doutb, doutb_valid, dbg_state
    );

    modport slave (
        input  clr_req, ena, wea, addra, dina, enb, addrb,
        output init_busy, doutb, doutb_valid, dbg_state
    );
endinterface

// File: rtl/bram_1r1w_be_clr.sv
// 1-read/1-write block RAM with byte-lane write enables, optional output
// register, optional write-to-read bypass and a zeroing clear engine.
module bram_1r1w_be_clr #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 256,
    parameter int MEMSIZE    = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
) (
    input logic               clk,
    input logic               rst,
    bram_1r1w_be_clr_if.slave bus
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH+1)'(MEMSIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMSIZE - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_wr, wr_go, rd_go;
    logic                  wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0] old_word, rd_word;
    logic [DATA_WIDTH-1:0] ram [MEMSIZE];

    assign wr_in_range   = {1'b0, bus.addra} < MEM_LIMIT;
    assign rd_in_range   = {1'b0, bus.addrb} < MEM_LIMIT;
    assign bus.init_busy = (state_q == S_CLEAR);
    assign bus.dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // While clearing, the engine owns the array and both ports are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_wr  = 1'b0;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clr_wr = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (bus.clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_go = bus.ena && wr_in_range;
                    rd_go = bus.enb;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_wr) begin
                ram[cnt_q] <= '0;
            end else if (wr_go) begin
                for (int i = 0; i < NB; i++) begin
                    if (bus.wea[i]) begin
                        ram[bus.addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    assign old_word = rd_in_range ? ram[bus.addrb] : '0;

    // A same-address write in the read cycle shows its enabled lanes when bypassing.
    always_comb begin
        rd_word = old_word;
        if (BYPASS != 0 && wr_go && bus.addra == bus.addrb) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.wea[i]) begin
                    rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.dina[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  p1_valid;
            logic [DATA_WIDTH-1:0] p1_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    p1_valid        <= 1'b0;
                    p1_data         <= '0;
                    bus.doutb       <= '0;
                    bus.doutb_valid <= 1'b0;
                end else begin
                    p1_valid        <= rd_go;
                    bus.doutb_valid <= p1_valid;
                    if (rd_go) begin
                        p1_data <= rd_word;
                    end
                    if (p1_valid) begin
                        bus.doutb <= p1_data;
                    end
                end
            end
        end else begin : g_noreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    bus.doutb       <= '0;
                    bus.doutb_valid <= 1'b0;
                end else begin
                    bus.doutb_valid <= rd_go;
                    if (rd_go) begin
                        bus.doutb <= rd_word;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_bram_1r1w_be_clr.sv
// Bench for bram_1r1w_be_clr: two instances (1-cycle/bypass/64 words and
// 2-cycle/no-bypass/48 words) share stimulus and are checked against a word model.
module tb_bram_1r1w_be_clr;
  localparam int AW  = 6;
  localparam int DW  = 256;
  localparam int BW  = 8;
  localparam int NB  = DW / BW;
  localparam int MS0 = 64;
  localparam int MS1 = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          clr_req = 1'b0;
  logic          ena     = 1'b0;
  logic          enb     = 1'b0;
  logic [NB-1:0] wea     = '0;
  logic [AW-1:0] addra   = '0;
  logic [AW-1:0] addrb   = '0;
  logic [DW-1:0] dina    = '0;

  bram_1r1w_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) b0 ();
  bram_1r1w_be_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(BW)) b1 ();

  assign b0.clr_req = clr_req;
  assign b0.ena     = ena;
  assign b0.wea     = wea;
  assign b0.addra   = addra;
  assign b0.dina    = dina;
  assign b0.enb     = enb;
  assign b0.addrb   = addrb;
  assign b1.clr_req = clr_req;
  assign b1.ena     = ena;
  assign b1.wea     = wea;
  assign b1.addra   = addra;
  assign b1.dina    = dina;
  assign b1.enb     = enb;
  assign b1.addrb   = addrb;

  bram_1r1w_be_clr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMSIZE(MS0), .BYTE_WIDTH(BW), .OUT_REG(0), .BYPASS(1)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  bram_1r1w_be_clr #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEMSIZE(MS1), .BYTE_WIDTH(BW), .OUT_REG(1), .BYPASS(0)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] mem_m [MS0];
  bit            model_idle = 1'b0;
  logic [DW-1:0] e0, e1;

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [NB-1:0] w);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (w[i]) r[i*BW +: BW] = d[i*BW +: BW];
    return r;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < MS0; i++) mem_m[i] = '0;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic c, input logic e_a, input logic [NB-1:0] w, input logic [AW-1:0] aa,
                       input logic [DW-1:0] d, input logic e_b, input logic [AW-1:0] ab);
    logic [DW-1:0] old;
    clr_req = c; ena = e_a; wea = w; addra = aa; dina = d; enb = e_b; addrb = ab;
    if (model_idle) begin
      if (c) begin
        model_idle = 1'b0;
        model_zero();
      end else begin
        if (e_b) begin
          old = mem_m[ab];
          exp_q0.push_back((e_a && aa == ab) ? lane_merge(old, d, w) : old);
          exp_q1.push_back((int'(ab) < MS1) ? old : '0);
        end
        if (e_a) mem_m[aa] = lane_merge(mem_m[aa], d, w);
      end
    end
    @(posedge clk); #1;
    clr_req = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic read(input int a);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
  endtask

  task automatic write(input int a, input logic [NB-1:0] w, input logic [DW-1:0] d);
    cycle(1'b0, 1'b1, w, AW'(a), d, 1'b0, '0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (b0.doutb_valid === 1'b1) begin
      total++;
      if (exp_q0.size() == 0) begin
        bad++;
        $display("FAIL dut0_read: unexpected valid pulse, doutb=%h", b0.doutb);
      end else begin
        e0 = exp_q0.pop_front();
        if (b0.doutb !== e0) begin
          bad++;
          $display("FAIL dut0_read: got %h want %h", b0.doutb, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b1.doutb_valid === 1'b1) begin
      total++;
      if (exp_q1.size() == 0) begin
        bad++;
        $display("FAIL dut1_read: unexpected valid pulse, doutb=%h", b1.doutb);
      end else begin
        e1 = exp_q1.pop_front();
        if (b1.doutb !== e1) begin
          bad++;
          $display("FAIL dut1_read: got %h want %h", b1.doutb, e1);
        end
      end
    end
  end

  // ---------------- common sequences ----------------
  task automatic drain();
    repeat (3) idle_cycle();
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain: pending reads dut0=%0d dut1=%0d want 0 0", exp_q0.size(), exp_q1.size());
    end
  endtask

  // Counts cycles until each instance drops init_busy; noise drives ignored traffic early on.
  task automatic wait_clear(input bit noise);
    int n, done0, done1;
    n = 0; done0 = 0; done1 = 0;
    total++;
    if (b0.init_busy !== 1'b1 || b1.init_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_rise: got %b %b want 1 1", b0.init_busy, b1.init_busy);
    end
    while ((done0 == 0 || done1 == 0) && n < 200) begin
      if (noise && n < 5) begin
        clr_req = 1'b1; ena = 1'b1; wea = '1; enb = 1'b1;
        addra = AW'($urandom_range(0, 63)); addrb = AW'($urandom_range(0, 63));
        dina = {8{$urandom}};
      end
      @(posedge clk); #1;
      clr_req = 1'b0; ena = 1'b0; enb = 1'b0; wea = '0;
      n++;
      if (done0 == 0 && b0.init_busy === 1'b0) done0 = n;
      if (done1 == 0 && b1.init_busy === 1'b0) done1 = n;
    end
    total++;
    if (done0 != MS0) begin
      bad++;
      $display("FAIL clear_len_dut0: got %0d want %0d", done0, MS0);
    end
    total++;
    if (done1 != MS1) begin
      bad++;
      $display("FAIL clear_len_dut1: got %0d want %0d", done1, MS1);
    end
    model_idle = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr_req = 1'b0; ena = 1'b0; enb = 1'b0;
    @(posedge clk); #1;
    exp_q0.delete(); exp_q1.delete();
    model_idle = 1'b0;
    model_zero();
    total++;
    if (b0.doutb !== '0 || b1.doutb !== '0) begin
      bad++;
      $display("FAIL rst_doutb: got %h / %h want 0", b0.doutb, b1.doutb);
    end
    total++;
    if (b0.doutb_valid !== 1'b0 || b1.doutb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_valid: got %b %b want 0 0", b0.doutb_valid, b1.doutb_valid);
    end
    total++;
    if (b0.dbg_state !== 1'b1 || b1.dbg_state !== 1'b1) begin
      bad++;
      $display("FAIL rst_state: got %b %b want 1 1", b0.dbg_state, b1.dbg_state);
    end
    rst = 1'b0;
    wait_clear(1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_read_all_zero();
    for (int a = 0; a < MS0; a++) read(a);
    drain();
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] want;
    want = {{7{32'h11223344}}, 32'h112233FF};
    write(5, '1, {8{32'h11223344}});
    write(5, NB'(1), {DW{1'b1}});
    read(5);
    @(negedge clk);
    total++;
    if (b0.doutb_valid !== 1'b1 || b1.doutb_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_edge1: valid got %b %b want 1 0", b0.doutb_valid, b1.doutb_valid);
    end
    total++;
    if (b0.doutb !== want) begin
      bad++;
      $display("FAIL lanes_dut0: got %h want %h", b0.doutb, want);
    end
    @(negedge clk);
    total++;
    if (b0.doutb_valid !== 1'b0 || b1.doutb_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_edge2: valid got %b %b want 0 1", b0.doutb_valid, b1.doutb_valid);
    end
    total++;
    if (b1.doutb !== want) begin
      bad++;
      $display("FAIL lanes_dut1: got %h want %h", b1.doutb, want);
    end
    drain();
  endtask

  task automatic test_bypass();
    write(9, '1, {32{8'hAA}});
    cycle(1'b0, 1'b1, NB'(3), AW'(9), {32{8'h55}}, 1'b1, AW'(9));
    read(9);
    drain();
  endtask

  task automatic test_back_to_back();
    int n0, n1, f0, f1, l0, l1;
    logic [DW-1:0] d;
    n0 = 0; n1 = 0; f0 = -1; f1 = -1; l0 = -1; l1 = -1;
    for (int a = 0; a < 8; a++) begin
      d = {8{$urandom}};
      d[7:0] = 8'(a + 1);
      write(a, '1, d);
    end
    fork
      begin
        for (int a = 0; a < 8; a++) read(a);
      end
      begin
        for (int k = 0; k < 14; k++) begin
          @(negedge clk);
          if (b0.doutb_valid === 1'b1) begin if (f0 < 0) f0 = k; n0++; l0 = k; end
          if (b1.doutb_valid === 1'b1) begin if (f1 < 0) f1 = k; n1++; l1 = k; end
        end
      end
    join
    total++;
    if (n0 != 8 || l0 - f0 != 7) begin
      bad++;
      $display("FAIL burst_dut0: pulses=%0d span=%0d want 8 7", n0, l0 - f0);
    end
    total++;
    if (n1 != 8 || l1 - f1 != 7) begin
      bad++;
      $display("FAIL burst_dut1: pulses=%0d span=%0d want 8 7", n1, l1 - f1);
    end
    total++;
    if (f1 != f0 + 1) begin
      bad++;
      $display("FAIL burst_lag: first pulse dut0=%0d dut1=%0d want lag 1", f0, f1);
    end
    drain();
  endtask

  task automatic test_out_of_range();
    write(47, '1, {32{8'h3C}});
    write(50, '1, {32{8'hC3}});
    read(47);
    read(50);
    read(63);
    drain();
  endtask

  task automatic test_clear_req();
    write(3, '1, {32{8'h77}});
    cycle(1'b1, 1'b1, '1, AW'(3), {32{8'h99}}, 1'b1, AW'(3));
    wait_clear(1'b1);
    for (int a = 0; a < MS0; a++) read(a);
    drain();
  endtask

  task automatic test_reset_mid();
    write(2, '1, {32{8'h5A}});
    read(2);
    do_reset();
    write(2, '1, {32{8'hA5}});
    cycle(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    repeat (10) idle_cycle();
    do_reset();
    read(2);
    drain();
  endtask

  task automatic test_random();
    logic [NB-1:0] w;
    for (int k = 0; k < 300; k++) begin
      w = ($urandom_range(0, 3) == 0) ? '0 : NB'($urandom);
      cycle(1'b0, 1'($urandom_range(0, 1)), w,
            AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(44, 63)),
            {8{$urandom}}, 1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(44, 63)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_read_all_zero();
    test_byte_lanes();
    test_bypass();
    test_back_to_back();
    test_out_of_range();
    test_clear_req();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/bram_1r1w_be_clr.md
Name: bram_1r1w_be_clr

Overview:
- Single-clock, parametrised 1-read/1-write block RAM for cache tag/data arrays and predictor tables.
- Generalises the plain 1r1w BRAM with:
  - per-byte write enables
  - selectable read latency (1 or 2 cycles)
  - optional write-to-read forwarding
  - a hardware clear engine that zeroes the array after reset or on request
- Downstream logic waits on init_busy before use and qualifies read data with doutb_valid.

Parameters:
- ADDR_WIDTH, 6, address width in bits.
- DATA_WIDTH, 256, word width in bits; must be a multiple of BYTE_WIDTH.
- MEMSIZE, 64, number of words; MEMSIZE <= 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.
- BYPASS, 1, 1 = same-cycle same-address read returns merged new data; 0 = returns old data.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  request full-array clear; sampled only in IDLE.
- init_busy  out  1  high while the clear engine owns the array.
- ena  in  1  write port enable.
- wea  in  NB  per-lane write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH].
- addra  in  ADDR_WIDTH  write address.
- dina  in  DATA_WIDTH  write data.
- enb  in  1  read request.
- addrb  in  ADDR_WIDTH  read address.
- doutb  out  DATA_WIDTH  read data; holds its last value when no read completes.
- doutb_valid  out  1  one-cycle pulse per completed read.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a posedge):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - doutb=0, doutb_valid=0, init_busy=1; the read pipeline is flushed.
  - Asserting rst mid-clear or mid-read restarts the clear from word 0 and discards in-flight reads (no valid pulse).
- FSM states: IDLE, CLEAR.
  - CLEAR:
    - Each cycle writes all-zero to ram[cnt], then cnt+1.
    - On the cycle that writes cnt==MEMSIZE-1, the next state is IDLE.
    - The clear takes exactly MEMSIZE cycles after rst deasserts; init_busy=1 throughout and drops in the first IDLE cycle.
  - CLEAR port behaviour: ena, enb and clr_req are ignored (no writes, no reads, no valid pulses, counter not restarted).
  - IDLE with clr_req=1:
    - Next state is CLEAR with cnt=0, and init_busy rises next cycle.
    - ena and enb in that same cycle are dropped.
- Write (IDLE, ena=1, clr_req=0):
  - Only lanes with wea[i]=1 update; other lanes keep their contents.
  - wea all-zero is a no-op.
  - addra >= MEMSIZE: write dropped.
- Read (IDLE, enb=1, clr_req=0):
  - Accepted at edge T.
  - OUT_REG=0: doutb/doutb_valid update at edge T+1.
  - OUT_REG=1: doutb/doutb_valid update at edge T+2.
  - Back-to-back reads are supported, one per cycle, fully pipelined.
  - addrb >= MEMSIZE: returns 0 with a valid pulse.
- Simultaneous read and write to the same address in the same cycle:
  - BYPASS=1: returned word = dina for lanes with wea=1, old contents for the other lanes.
  - BYPASS=0: returned word = old contents.
  - Either way, the array holds the new data afterwards.
- Ordering: a read in the cycle after a write always sees the written data.

Test Plan:
- Reset then idle, MEMSIZE=64 → init_busy=1 for exactly 64 cycles after rst falls. Then read every address → all 0x0, doutb_valid one pulse per read.
- Write addr 5, dina=0x..11223344, wea all-ones; then write addr 5, dina=0xFF..FF, wea=lane0 only; read addr 5 → low byte 0xFF, other bytes from the first write. OUT_REG=0 latency 1, OUT_REG=1 latency 2.
- Same-cycle write and read at addr 9: old=0xAA per byte, dina=0x55 per byte, wea=lanes 0-1. BYPASS=1 → lanes 0-1 return 0x55, the rest 0xAA; BYPASS=0 → all 0xAA. A following read of addr 9 → lanes 0-1 0x55 in both cases.
- Burst of 8 back-to-back reads at addr 0..7 holding distinct values → 8 consecutive valid pulses, data in address order, no bubbles, at both OUT_REG settings.
- clr_req in IDLE together with ena/enb → the write is dropped and no valid pulse occurs. init_busy rises next cycle for 64 cycles, and all words read 0 afterwards. clr_req and enb asserted during CLEAR → ignored.
- rst asserted 10 cycles into a clear, with a read in flight → no valid pulse, doutb=0, and the clear restarts and runs a full 64 cycles.
